// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the multi-zone temperature controller:
// zone state encoding and the threshold/dwell values loaded by reset.
package temp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOL    = 2'd1,
        HEAT    = 2'd2,
        LOCKOUT = 2'd3
    } zone_state_e;

    // Plain constants of the same encoding, used by the per-zone state register.
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COOL    = COOL;
    localparam logic [1:0] ST_HEAT    = HEAT;
    localparam logic [1:0] ST_LOCKOUT = LOCKOUT;

    // Values every zone returns to on reset.
    localparam int RST_COOL_TH = 100;
    localparam int RST_HEAT_TH = 40;
    localparam int RST_DWELL   = 4;

endpackage

// File: rtl/temp_zone_fsm.sv
// One climate zone: sampled temperature, threshold/dwell registers, the
// IDLE/COOL/HEAT/LOCKOUT controller and its dwell counter.
// Optional macro TEMP_CTRL_ALARM_EN adds a sticky over/under-range alarm.
//
// Handshake: cfg_we is a single-cycle strobe with no back-pressure; the new
// thresholds are used from the next cycle and the new dwell at the next load.
module temp_zone_fsm
    import temp_ctrl_pkg::*;
#(
    parameter int TW   = 8,
    parameter int HYST = 5,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] temp,
    input  logic          cfg_we,
    input  logic [TW-1:0] cfg_cool_th,
    input  logic [TW-1:0] cfg_heat_th,
    input  logic [DW-1:0] cfg_dwell,
`ifdef TEMP_CTRL_ALARM_EN
    input  logic          alarm_clr,
    output logic          alarm,
`endif
    output logic          cool_on,
    output logic          heat_on,
    output logic [1:0]    state_dbg
);

    // Two guard bits so threshold +/- hysteresis never wraps.
    localparam int XW = TW + 2;
    localparam logic [XW-1:0] HYST_X = XW'(HYST);
    localparam logic [XW-1:0] TMAX_X = {2'b00, {TW{1'b1}}};

    logic [TW-1:0] temp_q;
    logic [TW-1:0] cool_th;
    logic [TW-1:0] heat_th;
    logic [DW-1:0] dwell;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_dec;
    logic [DW-1:0] cnt_nxt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [XW-1:0] temp_x;
    logic [XW-1:0] cool_x;
    logic [XW-1:0] heat_x;
    logic [XW-1:0] cool_lo;
    logic [XW-1:0] heat_hi;
    logic          cnt_done;

    assign temp_x  = {2'b00, temp_q};
    assign cool_x  = {2'b00, cool_th};
    assign heat_x  = {2'b00, heat_th};
    assign cool_lo = (cool_x >= HYST_X) ? cool_x - HYST_X : '0;
    assign heat_hi = (heat_x + HYST_X > TMAX_X) ? TMAX_X : heat_x + HYST_X;

    // The counter saturates at 0; "done" means this cycle's decrement reaches 0,
    // so a dwell of N holds a state for N cycles (one cycle when N is 0 or 1).
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - DW'(1);
    assign cnt_done = (cnt_dec == '0);

    assign state_dbg = state;

    // Input sample stage: decisions act on the temperature captured one edge earlier.
    always_ff @(posedge clk) begin
        temp_q <= temp;
    end

    // Threshold and dwell registers, reloaded to defaults by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cool_th <= TW'(RST_COOL_TH);
            heat_th <= TW'(RST_HEAT_TH);
            dwell   <= DW'(RST_DWELL);
        end else if (cfg_we) begin
            cool_th <= cfg_cool_th;
            heat_th <= cfg_heat_th;
            dwell   <= cfg_dwell;
        end
    end

    // Next-state and counter logic; cooling takes priority over heating in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_dec;
        case (state)
            ST_IDLE: begin
                if (temp_x >= cool_x) begin
                    state_nxt = ST_COOL;
                    cnt_nxt   = dwell;
                end else if (temp_x <= heat_x) begin
                    state_nxt = ST_HEAT;
                    cnt_nxt   = dwell;
                end
            end
            ST_COOL: begin
                if (temp_x <= cool_lo && cnt_done) begin
                    state_nxt = ST_LOCKOUT;
                    cnt_nxt   = dwell;
                end
            end
            ST_HEAT: begin
                if (temp_x >= heat_hi && cnt_done) begin
                    state_nxt = ST_LOCKOUT;
                    cnt_nxt   = dwell;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and actuator registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cool_on <= 1'b0;
            heat_on <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cool_on <= (state_nxt == ST_COOL);
            heat_on <= (state_nxt == ST_HEAT);
        end
    end

`ifdef TEMP_CTRL_ALARM_EN
    localparam logic [XW-1:0] HYST2_X = XW'(2 * HYST);

    logic [XW-1:0] alarm_hi;
    logic [XW-1:0] alarm_lo;

    assign alarm_hi = (cool_x + HYST2_X > TMAX_X) ? TMAX_X : cool_x + HYST2_X;
    assign alarm_lo = (heat_x >= HYST2_X) ? heat_x - HYST2_X : '0;

    // Sticky alarm: a live out-of-range condition beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (temp_x >= alarm_hi || temp_x <= alarm_lo) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/multi_zone_temp_control.sv
// Multi-zone temperature controller top: configuration decode/validation and
// NZONES independent temp_zone_fsm instances.
// Optional macro TEMP_CTRL_ALARM_EN adds the alarm/alarm_clr ports.
//
// Handshake: cfg_wr is a single-cycle strobe with no ready; a write whose
// zone is out of range or whose thresholds overlap the hysteresis bands is
// dropped and answered by a one-cycle cfg_err on the following cycle.
module multi_zone_temp_control
    import temp_ctrl_pkg::*;
#(
    parameter int NZONES = 4,
    parameter int TW     = 8,
    parameter int HYST   = 5,
    parameter int DW     = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NZONES*TW-1:0]                         zone_temp,
    input  logic                                         cfg_wr,
    input  logic [((NZONES > 1) ? $clog2(NZONES) : 1)-1:0] cfg_zone,
    input  logic [TW-1:0]                                cfg_cool_th,
    input  logic [TW-1:0]                                cfg_heat_th,
    input  logic [DW-1:0]                                cfg_dwell,
    output logic                                         cfg_err,
    output logic [NZONES-1:0]                            cool_on,
    output logic [NZONES-1:0]                            heat_on,
`ifdef TEMP_CTRL_ALARM_EN
    input  logic [NZONES-1:0]                            alarm_clr,
    output logic [NZONES-1:0]                            alarm,
`endif
    output logic [2*NZONES-1:0]                          zone_state
);

    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;
    localparam int XW = TW + 2;

    logic th_ok;
    logic zone_ok;
    logic cfg_ok;

    // heat_th + HYST < cool_th - HYST, rearranged so nothing is subtracted.
    assign th_ok   = ({2'b00, cfg_heat_th} + XW'(2 * HYST)) < {2'b00, cfg_cool_th};
    assign zone_ok = {1'b0, cfg_zone} < (ZW + 1)'(NZONES);
    assign cfg_ok  = cfg_wr && th_ok && zone_ok;

    // Rejected writes raise cfg_err for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !(th_ok && zone_ok);
        end
    end

    for (genvar i = 0; i < NZONES; i++) begin : g_zone
        logic zone_we;

        assign zone_we = cfg_ok && (cfg_zone == ZW'(i));

        temp_zone_fsm #(
            .TW   (TW),
            .HYST (HYST),
            .DW   (DW)
        ) u_zone (
            .clk         (clk),
            .rst         (rst),
            .temp        (zone_temp[i*TW +: TW]),
            .cfg_we      (zone_we),
            .cfg_cool_th (cfg_cool_th),
            .cfg_heat_th (cfg_heat_th),
            .cfg_dwell   (cfg_dwell),
`ifdef TEMP_CTRL_ALARM_EN
            .alarm_clr   (alarm_clr[i]),
            .alarm       (alarm[i]),
`endif
            .cool_on     (cool_on[i]),
            .heat_on     (heat_on[i]),
            .state_dbg   (zone_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_multi_zone_temp_control.sv
// Bench for multi_zone_temp_control (3 zones so an out-of-range cfg_zone
// exists). A cycle model predicts outputs; predictions are queued when the
// stimulus is applied and compared after the following clock edge.
module tb_multi_zone_temp_control;

    localparam int NZ   = 3;
    localparam int TW   = 8;
    localparam int HYST = 5;
    localparam int DW   = 8;
    localparam int ZW   = 2;
    localparam int W    = 4 * NZ + 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst;
    logic [NZ*TW-1:0]  zone_temp;
    logic              cfg_wr;
    logic [ZW-1:0]     cfg_zone;
    logic [TW-1:0]     cfg_cool_th;
    logic [TW-1:0]     cfg_heat_th;
    logic [DW-1:0]     cfg_dwell;
    logic              cfg_err;
    logic [NZ-1:0]     cool_on;
    logic [NZ-1:0]     heat_on;
    logic [2*NZ-1:0]   zone_state;
`ifdef TEMP_CTRL_ALARM_EN
    logic [NZ-1:0]     alarm_clr;
    logic [NZ-1:0]     alarm;
    logic [NZ-1:0]     al_q[$];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_zone_temp_control #(
        .NZONES (NZ),
        .TW     (TW),
        .HYST   (HYST),
        .DW     (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .zone_temp   (zone_temp),
        .cfg_wr      (cfg_wr),
        .cfg_zone    (cfg_zone),
        .cfg_cool_th (cfg_cool_th),
        .cfg_heat_th (cfg_heat_th),
        .cfg_dwell   (cfg_dwell),
        .cfg_err     (cfg_err),
        .cool_on     (cool_on),
        .heat_on     (heat_on),
`ifdef TEMP_CTRL_ALARM_EN
        .alarm_clr   (alarm_clr),
        .alarm       (alarm),
`endif
        .zone_state  (zone_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // States: 0 idle, 1 cool, 2 heat, 3 lockout. m_tq is the temperature the
    // design will act on at the coming edge (sampled one edge earlier).
    int m_state[NZ];
    int m_cnt[NZ];
    int m_tq[NZ];
    int m_cool[NZ];
    int m_heat[NZ];
    int m_dwell[NZ];
    int m_alarm[NZ];
    int m_err;

    task automatic model_step();
        int lo, hi, rem, ahi, alo, zi;
        if (rst) begin
            for (int z = 0; z < NZ; z++) begin
                m_state[z] = 0; m_cnt[z] = 0; m_alarm[z] = 0;
                m_cool[z] = 100; m_heat[z] = 40; m_dwell[z] = 4;
            end
            m_err = 0;
        end else begin
            for (int z = 0; z < NZ; z++) begin
                lo  = (m_cool[z] - HYST < 0) ? 0 : m_cool[z] - HYST;
                hi  = (m_heat[z] + HYST > 255) ? 255 : m_heat[z] + HYST;
                rem = (m_cnt[z] == 0) ? 0 : m_cnt[z] - 1;
                case (m_state[z])
                    0: if (m_tq[z] >= m_cool[z]) begin m_state[z] = 1; m_cnt[z] = m_dwell[z]; end
                       else if (m_tq[z] <= m_heat[z]) begin m_state[z] = 2; m_cnt[z] = m_dwell[z]; end
                    1: if (m_tq[z] <= lo && rem == 0) begin m_state[z] = 3; m_cnt[z] = m_dwell[z]; end
                       else m_cnt[z] = rem;
                    2: if (m_tq[z] >= hi && rem == 0) begin m_state[z] = 3; m_cnt[z] = m_dwell[z]; end
                       else m_cnt[z] = rem;
                    default: begin m_cnt[z] = rem; if (rem == 0) m_state[z] = 0; end
                endcase
`ifdef TEMP_CTRL_ALARM_EN
                ahi = (m_cool[z] + 2 * HYST > 255) ? 255 : m_cool[z] + 2 * HYST;
                alo = (m_heat[z] - 2 * HYST < 0) ? 0 : m_heat[z] - 2 * HYST;
                if (m_tq[z] >= ahi || m_tq[z] <= alo) m_alarm[z] = 1;
                else if (alarm_clr[z]) m_alarm[z] = 0;
`else
                ahi = 0; alo = 0;
`endif
            end
            m_err = 0;
            if (cfg_wr) begin
                zi = int'(cfg_zone);
                if (zi < NZ && int'(cfg_heat_th) + 2 * HYST < int'(cfg_cool_th)) begin
                    m_cool[zi] = int'(cfg_cool_th);
                    m_heat[zi] = int'(cfg_heat_th);
                    m_dwell[zi] = int'(cfg_dwell);
                end else begin
                    m_err = 1;
                end
            end
        end
        for (int z = 0; z < NZ; z++) m_tq[z] = int'(zone_temp[z*TW +: TW]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [W-1:0] e;
        logic [W-1:0] got;
`ifdef TEMP_CTRL_ALARM_EN
        logic [NZ-1:0] ae;
`endif
        model_step();
        e = '0;
        for (int z = 0; z < NZ; z++) begin
            e[z]                  = (m_state[z] == 1);
            e[NZ + z]             = (m_state[z] == 2);
            e[2*NZ + 1 + 2*z +: 2] = 2'(m_state[z]);
        end
        e[2*NZ] = (m_err != 0);
        exp_q.push_back(e);
`ifdef TEMP_CTRL_ALARM_EN
        for (int z = 0; z < NZ; z++) ae[z] = (m_alarm[z] != 0);
        al_q.push_back(ae);
`endif
        @(posedge clk);
        #1;
        got = {zone_state, cfg_err, heat_on, cool_on};
        e = exp_q.pop_front();
        check({phase, ":cool_on"}, 64'(got[NZ-1:0]), 64'(e[NZ-1:0]));
        check({phase, ":heat_on"}, 64'(got[2*NZ-1:NZ]), 64'(e[2*NZ-1:NZ]));
        check({phase, ":cfg_err"}, 64'(got[2*NZ]), 64'(e[2*NZ]));
        check({phase, ":state"}, 64'(got[W-1:2*NZ+1]), 64'(e[W-1:2*NZ+1]));
        check({phase, ":exclusive"}, 64'(cool_on & heat_on), 64'(0));
`ifdef TEMP_CTRL_ALARM_EN
        ae = al_q.pop_front();
        check({phase, ":alarm"}, 64'(alarm), 64'(ae));
`endif
    endtask

    task automatic set_temp(input int z, input int t);
        zone_temp[z*TW +: TW] = TW'(t);
    endtask

    task automatic cfg_write(input int z, input int h, input int c, input int d);
        cfg_wr      = 1'b1;
        cfg_zone    = ZW'(z);
        cfg_heat_th = TW'(h);
        cfg_cool_th = TW'(c);
        cfg_dwell   = DW'(d);
        tick();
        cfg_wr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_c, n_l;
        rst = 1'b1; cfg_wr = 1'b0; cfg_zone = '0;
        cfg_cool_th = '0; cfg_heat_th = '0; cfg_dwell = '0;
`ifdef TEMP_CTRL_ALARM_EN
        alarm_clr = '0;
`endif
        for (int z = 0; z < NZ; z++) set_temp(z, 70);

        phase = "reset";
        tick();
        cfg_write(0, 10, 50, 2);    // valid write under reset must be ignored
        check("reset_outputs", 64'({cool_on, heat_on, cfg_err}), 64'(0));
        rst = 1'b0;
        repeat (3) tick();
        check("reset_beats_cfg", 64'(cool_on[0]), 64'(0));

        phase = "cool_entry";
        set_temp(0, 99);  tick();
        set_temp(0, 100); tick();
        check("cool_not_yet", 64'(cool_on[0]), 64'(0));
        set_temp(0, 90);  tick();
        check("cool_rise", 64'(cool_on[0]), 64'(1));
        check("cool_others", 64'({cool_on[2:1], heat_on}), 64'(0));
        n_c = 1; n_l = 0;
        repeat (12) begin
            tick();
            n_c += int'(cool_on[0]);
            n_l += int'(zone_state[1:0] == 2'd3);
        end
        check("cool_len", 64'(n_c), 64'(4));
        check("lockout_len", 64'(n_l), 64'(4));

        phase = "heat";
        set_temp(1, 30); tick();
        set_temp(1, 44); repeat (8) tick();
        check("heat_hold_44", 64'(heat_on[1]), 64'(1));
        set_temp(1, 45); tick(); tick();
        check("heat_to_lockout", 64'(zone_state[3:2]), 64'(3));
        set_temp(1, 70); repeat (8) tick();

        phase = "cfg";
        cfg_write(2, 60, 70, 4);
        check("cfg_reject_err", 64'(cfg_err), 64'(1));
        tick();
        check("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
        cfg_write(2, 30, 90, 4);
        check("cfg_accept_err", 64'(cfg_err), 64'(0));
        set_temp(2, 95); tick(); tick();
        check("cfg_new_cool_th", 64'(cool_on[2]), 64'(1));
        set_temp(2, 70); repeat (12) tick();
        cfg_write(3, 30, 90, 4);
        check("cfg_zone_oob", 64'(cfg_err), 64'(1));
        cfg_write(0, 0, 3, 4);
        check("cool_lo_no_wrap", 64'(cfg_err), 64'(1));

        phase = "dwell0";
        cfg_write(0, 40, 100, 0);
        check("dwell0_accept", 64'(cfg_err), 64'(0));
        set_temp(0, 100); tick();
        set_temp(0, 90);  tick();
        check("dwell0_cool", 64'(cool_on[0]), 64'(1));
        n_c = 1; n_l = 0;
        repeat (6) begin
            tick();
            n_c += int'(cool_on[0]);
            n_l += int'(zone_state[1:0] == 2'd3);
        end
        check("dwell0_cool_len", 64'(n_c), 64'(1));
        check("dwell0_lockout_len", 64'(n_l), 64'(1));

        phase = "random";
        repeat (300) begin
            for (int z = 0; z < NZ; z++) set_temp(z, $urandom_range(0, 255));
`ifdef TEMP_CTRL_ALARM_EN
            alarm_clr = NZ'($urandom_range(0, 7));
`endif
            if ($urandom_range(0, 11) == 0)
                cfg_write($urandom_range(0, 3), $urandom_range(0, 80),
                          $urandom_range(0, 180), $urandom_range(0, 6));
            else
                tick();
        end
`ifdef TEMP_CTRL_ALARM_EN
        alarm_clr = '0;
`endif

        phase = "reset_mid_heat";
        for (int z = 0; z < NZ; z++) set_temp(z, 70);
        cfg_write(1, 40, 100, 4);
        set_temp(1, 20);
        repeat (20) tick();
        check("pre_reset_heat", 64'(heat_on[1]), 64'(1));
        rst = 1'b1;
        cfg_write(2, 10, 50, 2);
        check("reset_heat_drop", 64'(heat_on[1]), 64'(0));
        rst = 1'b0;
        set_temp(2, 95); repeat (4) tick();
        check("default_cool_th_95", 64'(cool_on[2]), 64'(0));
        set_temp(2, 100); tick(); tick();
        check("default_cool_th_100", 64'(cool_on[2]), 64'(1));
        set_temp(0, 41); repeat (3) tick();
        check("default_heat_th_41", 64'(heat_on[0]), 64'(0));
        set_temp(0, 40); tick(); tick();
        check("default_heat_th_40", 64'(heat_on[0]), 64'(1));

`ifdef TEMP_CTRL_ALARM_EN
        phase = "alarm";
        set_temp(0, 110); tick(); tick();
        check("alarm_set", 64'(alarm[0]), 64'(1));
        set_temp(0, 70); repeat (3) tick();
        check("alarm_sticky", 64'(alarm[0]), 64'(1));
        alarm_clr[0] = 1'b1; tick();
        alarm_clr[0] = 1'b0;
        check("alarm_cleared", 64'(alarm[0]), 64'(0));
        set_temp(0, 110); tick();
        alarm_clr[0] = 1'b1; tick(); tick();
        check("alarm_set_wins", 64'(alarm[0]), 64'(1));
        alarm_clr[0] = 1'b0;
        set_temp(0, 70); repeat (12) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
